// File: rtl/ray_pkg.sv
// rtl/ray_pkg.sv - shared types and constants for the camera-ray direction source
package ray_pkg;

    typedef logic [31:0] float32_t;

    localparam int PIX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rdg_state_t;

endpackage

// File: rtl/ray_dir_gen_if.sv
// rtl/ray_dir_gen_if.sv - float32 direction stream with downstream ready
interface ray_dir_gen_if;
    import ray_pkg::*;

    float32_t v_x;
    float32_t v_y;
    float32_t v_z;
    logic     v_valid;
    logic     ready_in;

    modport master (
        output v_x, v_y, v_z, v_valid,
        input  ready_in
    );

    modport slave (
        input  v_x, v_y, v_z, v_valid,
        output ready_in
    );

endinterface

// File: rtl/sint32_to_float.sv
// rtl/sint32_to_float.sv - signed 32-bit integer to IEEE-754 single, CVT_LAT enabled stages
module sint32_to_float
    import ray_pkg::*;
#(
    parameter int CVT_LAT = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        en_in,
    input  logic        valid_in,
    input  logic [31:0] a_in,
    output logic        valid_out,
    output logic [31:0] f_out
);

    // Normalise so the leading one sits at bit 31; bits [7:0] are then guard/sticky for RNE.
    function automatic float32_t to_f32(input logic [31:0] a);
        logic        sign;
        logic [31:0] mag;
        logic [31:0] norm;
        logic [4:0]  msb;
        logic        rnd;
        logic [24:0] man;
        logic [7:0]  exp_b;
        sign  = a[31];
        mag   = sign ? (~a + 32'd1) : a;
        msb   = '0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) msb = 5'(i);
        end
        norm  = mag << (5'd31 - msb);
        rnd   = norm[7] & ((|norm[6:0]) | norm[8]);
        man   = {1'b0, norm[31:8]} + 25'(rnd);
        exp_b = 8'd127 + 8'(msb) + 8'(man[24]);
        if (mag == '0) return '0;
        return {sign, exp_b, (man[24] ? man[23:1] : man[22:0])};
    endfunction

    float32_t            data_q [CVT_LAT];
    logic [CVT_LAT-1:0]  vld_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vld_q <= '0;
            for (int i = 0; i < CVT_LAT; i++) data_q[i] <= '0;
        end else if (en_in) begin
            vld_q[0]  <= valid_in;
            data_q[0] <= to_f32(a_in);
            for (int i = 1; i < CVT_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign valid_out = vld_q[CVT_LAT-1];
    assign f_out     = data_q[CVT_LAT-1];

endmodule

// File: rtl/ray_dir_gen.sv
// rtl/ray_dir_gen.sv - raster-scan camera-ray direction source; RAY_DIR_GEN_PIXEL_TAG_EN adds pixel tag ports
module ray_dir_gen
    import ray_pkg::*;
#(
    parameter int H_RES   = 320,
    parameter int V_RES   = 180,
    parameter int FOCAL   = 256,
    parameter int CVT_LAT = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    ray_dir_gen_if.master        dir,
    output logic                 busy_out,
    output logic                 frame_done_out
`ifdef RAY_DIR_GEN_PIXEL_TAG_EN
    ,
    output logic [PIX_W-1:0]     pix_x_out,
    output logic [PIX_W-1:0]     pix_y_out
`endif
);

    localparam int OCC_W = $clog2(CVT_LAT + 2);

    rdg_state_t        state_q, state_d;
    logic [PIX_W-1:0]  px_q, py_q;
    logic [OCC_W-1:0]  inflight_q;
    logic              en, issue, last_pix, xfer, last_valid, pipe_empty;
    logic              vx, vy, vz;
    logic [31:0]       dx, dy, dz;

    // ready_in is the single global enable: counters and every stage freeze together.
    assign en         = dir.ready_in;
    assign issue      = (state_q == RUN) && en;
    assign last_pix   = (px_q == PIX_W'(H_RES - 1)) && (py_q == PIX_W'(V_RES - 1));
    assign last_valid = vx & vy & vz;
    assign xfer       = last_valid & en;
    assign pipe_empty = (inflight_q == '0);
    assign dir.v_valid = xfer;

    always_comb begin
        state_d        = state_q;
        busy_out       = 1'b0;
        frame_done_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) state_d = RUN;
            end
            RUN: begin
                busy_out = 1'b1;
                if (issue && last_pix) state_d = DRAIN;
            end
            DRAIN: begin
                if (pipe_empty) begin
                    frame_done_out = 1'b1;
                    state_d        = IDLE;
                end else begin
                    busy_out = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            px_q       <= '0;
            py_q       <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_q + OCC_W'(issue) - OCC_W'(xfer);
            if (issue) begin
                if (px_q == PIX_W'(H_RES - 1)) begin
                    px_q <= '0;
                    py_q <= last_pix ? '0 : py_q + 1'b1;
                end else begin
                    px_q <= px_q + 1'b1;
                end
            end
        end
    end

    assign dx = 32'(px_q) - 32'(H_RES / 2);
    assign dy = 32'(V_RES / 2) - 32'(py_q);
    assign dz = 32'(FOCAL);

    sint32_to_float #(.CVT_LAT(CVT_LAT)) u_cvt_x (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(en), .valid_in(issue),
        .a_in(dx), .valid_out(vx), .f_out(dir.v_x)
    );

    sint32_to_float #(.CVT_LAT(CVT_LAT)) u_cvt_y (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(en), .valid_in(issue),
        .a_in(dy), .valid_out(vy), .f_out(dir.v_y)
    );

    sint32_to_float #(.CVT_LAT(CVT_LAT)) u_cvt_z (
        .clk_in(clk_in), .rst_in(rst_in), .en_in(en), .valid_in(issue),
        .a_in(dz), .valid_out(vz), .f_out(dir.v_z)
    );

`ifdef RAY_DIR_GEN_PIXEL_TAG_EN
    logic [PIX_W-1:0] tag_x_q [CVT_LAT];
    logic [PIX_W-1:0] tag_y_q [CVT_LAT];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < CVT_LAT; i++) begin
                tag_x_q[i] <= '0;
                tag_y_q[i] <= '0;
            end
        end else if (en) begin
            tag_x_q[0] <= px_q;
            tag_y_q[0] <= py_q;
            for (int i = 1; i < CVT_LAT; i++) begin
                tag_x_q[i] <= tag_x_q[i-1];
                tag_y_q[i] <= tag_y_q[i-1];
            end
        end
    end

    assign pix_x_out = tag_x_q[CVT_LAT-1];
    assign pix_y_out = tag_y_q[CVT_LAT-1];
`endif

endmodule
